ls_queue: RTL
=============

Name: ls_queue

Overview:
Parametrised in-order load/store queue between dispatcher and LS unit. Entries wake up on NUM_CDB result broadcast channels and issue strictly in program order through a valid/ready handshake. Entries retire from the head on LS completion. Branch-tagged entries are squashed on misprediction by pulling the tail back.

Parameters:
DEPTH, 16, number of entries; power of two, >=2
DATA_W, 32, operand/imm/result width
TAG_W, 5, rename tag width; tag value 0 = operand ready (no dependency)
OP_W, 6, opcode width
BR_W, 4, branch mask width (one bit per in-flight branch)
NUM_CDB, 2, number of result broadcast channels

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  channel c at [c*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  channel c at [c*DATA_W +: DATA_W]
alloc_valid  in  1  dispatcher allocation request
alloc_ready  out  1  not full (combinational from count)
alloc_op  in  OP_W  opcode
alloc_tag1/alloc_tag2  in  TAG_W  source tags (0 = data valid)
alloc_data1/alloc_data2  in  DATA_W  source values
alloc_imm  in  DATA_W  address offset
alloc_dst  in  TAG_W  destination tag
alloc_brmask  in  BR_W  unresolved branches this op depends on
issue_valid  out  1  registered issue packet valid
issue_ready  in  1  LS unit accepts packet
issue_op/issue_dst  out  OP_W/TAG_W  packet fields
issue_data1/issue_data2/issue_imm  out  DATA_W  packet fields
ls_done  in  1  head entry completed; retire
br_resolve_en  in  1  branch resolved this cycle
br_resolve_idx  in  $clog2(BR_W)  resolved branch bit
br_mispredict  in  1  qualifies br_resolve_en: squash
count  out  $clog2(DEPTH+1)  occupied entries
empty  out  1  count==0

Behaviour:
- Circular buffer with head (oldest unretired), iptr (next to issue) and tail (next free). Order: head <= iptr <= tail modulo wrap. Separate count register disambiguates full from empty.
- Reset (async): head=iptr=tail=0, count=0, all entry valid bits 0. issue_valid=0 and all issue_* fields 0. alloc_ready=1, empty=1.
- Alloc: if alloc_valid && alloc_ready && !(br_resolve_en && br_mispredict), write the entry at tail and advance tail (wrapping DEPTH-1 -> 0).
- Alloc bypass: any source tag matching an active CDB channel in the same cycle is stored as ready with the CDB data. If br_resolve_en && !br_mispredict, bit idx of alloc_brmask is cleared on write.
- Wakeup: each cycle, every valid entry with a nonzero tag equal to an active cdb_tag captures that data and clears its tag. If multiple channels match, the lowest channel index wins.
- Branch clear: on a correct resolve, bit idx is cleared in all entries.
- Issue eligibility: the entry at iptr is valid, both tags are 0 after this cycle's wakeup, and its mask is 0 after this cycle's clear.
- Issue handshake: the output register loads when (!issue_valid || issue_ready) and the entry at iptr is eligible. It then loads data with same-cycle CDB bypass and advances iptr. Otherwise, if issue_ready, issue_valid drops to 0. Packet fields hold stable while issue_valid && !issue_ready.
- Issue throughput: one issue per cycle max. Issue latency is 1 cycle after eligibility.
- Retire: ls_done pulses once per issued op, in order, and frees the entry at head. ls_done while head==iptr is illegal (assertion).
- Mispredict (br_resolve_en && br_mispredict): every valid entry with mask bit idx set is invalidated. Such entries are contiguous from the oldest marked entry to tail-1. tail moves to the oldest marked entry and count is reduced accordingly.
  - Marked entries never issued, since mask!=0, so iptr is unaffected.
  - The issue register is never squashed.
  - Alloc is dropped that cycle. ls_done in the same cycle still retires the head.
- Simultaneous alloc + retire keeps count unchanged. alloc at full is ignored; alloc_ready=0 at full.
- count/empty reflect registered state; alloc_ready = (count != DEPTH).

Test Plan:
- Reset mid-operation: 3 entries queued with issue_valid=1, assert rst -> same cycle issue_valid=0, count=0, empty=1, alloc_ready=1.
- Alloc ld tag1=7; next cycle cdb ch1 tag 7 data 0x1234 -> issue_valid=1 one cycle later, issue_data1=0x1234. Alloc in same cycle as the cdb tag-7 broadcast -> captured via bypass.
- Fill DEPTH=16 with ready ops, hold issue_ready=0 -> alloc_ready=0, count=16, a 17th alloc is ignored. Release issue_ready and pulse ls_done per issue -> all 16 issue in allocation order, pointers wrap to 0, empty=1.
- Entries A(mask 0), B(mask 0010), C(mask 0010), mispredict idx 1 -> B and C squashed, tail=A+1, count=1, and a same-cycle alloc is dropped. Repeat with a correct resolve -> B and C issue.
- Head op blocked on tag 9 while a younger op is ready -> no issue until tag 9 broadcasts (in-order). Two channels broadcasting tag 9 with different data -> channel 0 data taken.

Source files
------------

// File: rtl/ls_queue_if.sv
// Dispatcher-to-queue allocation bus and queue-to-LS-unit issue bus.
// master: the dispatcher/LS-unit side; slave: the load/store queue.
interface ls_queue_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6,
    parameter int BR_W   = 4
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic [OP_W-1:0]   alloc_op;
    logic [TAG_W-1:0]  alloc_tag1;
    logic [TAG_W-1:0]  alloc_tag2;
    logic [DATA_W-1:0] alloc_data1;
    logic [DATA_W-1:0] alloc_data2;
    logic [DATA_W-1:0] alloc_imm;
    logic [TAG_W-1:0]  alloc_dst;
    logic [BR_W-1:0]   alloc_brmask;

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_dst;
    logic [DATA_W-1:0] issue_data1;
    logic [DATA_W-1:0] issue_data2;
    logic [DATA_W-1:0] issue_imm;

    modport master (
        output alloc_valid, alloc_op, alloc_tag1, alloc_tag2, alloc_data1,
               alloc_data2, alloc_imm, alloc_dst, alloc_brmask, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_dst, issue_data1,
               issue_data2, issue_imm
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_tag1, alloc_tag2, alloc_data1,
               alloc_data2, alloc_imm, alloc_dst, alloc_brmask, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_dst, issue_data1,
               issue_data2, issue_imm
    );
endinterface

// File: rtl/ls_queue.sv
// In-order load/store queue: circular buffer with head (oldest unretired),
// iptr (next to issue) and tail (next free). Operands wake up from the CDB,
// ops issue strictly in order, retire from head, and branch squashes pull
// the tail back.
module ls_queue #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 6,
    parameter int BR_W    = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    ls_queue_if.slave                   bus,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic                        ls_done,
    input  logic                        br_resolve_en,
    input  logic [$clog2(BR_W)-1:0]     br_resolve_idx,
    input  logic                        br_mispredict,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Snoop all CDB channels for a tag; lowest channel index wins.
    // Returns {tag, data}: tag cleared and data replaced on a hit.
    function automatic logic [TAG_W+DATA_W-1:0] wake(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         data,
        input logic [NUM_CDB-1:0]        cv,
        input logic [NUM_CDB*TAG_W-1:0]  ct,
        input logic [NUM_CDB*DATA_W-1:0] cd
    );
        logic [TAG_W+DATA_W-1:0] r;
        r = {tag, data};
        if (tag != '0) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cv[c] && ct[c*TAG_W +: TAG_W] == tag)
                    r = {{TAG_W{1'b0}}, cd[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    logic [PTR_W-1:0]  head_q, head_d, iptr_q, iptr_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d, pend_q, pend_d;
    logic [DEPTH-1:0]  vld_q, vld_d;

    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [TAG_W-1:0]  dst_q  [DEPTH];
    logic [DATA_W-1:0] imm_q  [DEPTH];
    logic [TAG_W-1:0]  tag1_q [DEPTH], tag1_d [DEPTH], tag2_q [DEPTH], tag2_d [DEPTH];
    logic [DATA_W-1:0] d1_q   [DEPTH], d1_d   [DEPTH], d2_q   [DEPTH], d2_d   [DEPTH];
    logic [BR_W-1:0]   mask_q [DEPTH], mask_d [DEPTH];

    logic              iv_q;
    logic [OP_W-1:0]   iop_q;
    logic [TAG_W-1:0]  idst_q;
    logic [DATA_W-1:0] id1_q, id2_q, iimm_q;

    logic              br_squash, br_fix, alloc_fire, elig, issue_load;
    logic              sq_found;
    logic [PTR_W-1:0]  sq_tail;
    logic [CNT_W-1:0]  sq_cnt;

    assign br_squash  = br_resolve_en && br_mispredict;
    assign br_fix     = br_resolve_en && !br_mispredict;
    assign alloc_fire = bus.alloc_valid && bus.alloc_ready && !br_squash;

    // Post-wakeup / post-clear view of every entry, plus the alloc write at tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {tag1_d[i], d1_d[i]} = wake(tag1_q[i], d1_q[i], cdb_valid, cdb_tag, cdb_data);
            {tag2_d[i], d2_d[i]} = wake(tag2_q[i], d2_q[i], cdb_valid, cdb_tag, cdb_data);
            mask_d[i] = mask_q[i];
            if (br_fix)
                mask_d[i][br_resolve_idx] = 1'b0;
        end
        elig = (pend_q != '0) && vld_q[iptr_q] && (tag1_d[iptr_q] == '0) &&
               (tag2_d[iptr_q] == '0) && (mask_d[iptr_q] == '0);
        if (alloc_fire) begin
            {tag1_d[tail_q], d1_d[tail_q]} =
                wake(bus.alloc_tag1, bus.alloc_data1, cdb_valid, cdb_tag, cdb_data);
            {tag2_d[tail_q], d2_d[tail_q]} =
                wake(bus.alloc_tag2, bus.alloc_data2, cdb_valid, cdb_tag, cdb_data);
            mask_d[tail_q] = bus.alloc_brmask;
            if (br_fix)
                mask_d[tail_q][br_resolve_idx] = 1'b0;
        end
    end

    assign issue_load = (!iv_q || bus.issue_ready) && elig;

    // Find the oldest entry carrying the mispredicted branch bit; everything
    // from it to tail-1 is squashed.
    always_comb begin
        logic [PTR_W-1:0] p;
        sq_found = 1'b0;
        sq_tail  = tail_q;
        sq_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            p = head_q + PTR_W'(i);
            if (!sq_found && (CNT_W'(i) < count_q) && vld_q[p] &&
                mask_q[p][br_resolve_idx]) begin
                sq_found = 1'b1;
                sq_tail  = p;
                sq_cnt   = count_q - CNT_W'(i);
            end
        end
    end

    // Pointer, occupancy and entry-valid next state.
    always_comb begin
        vld_d = vld_q;
        if (ls_done)
            vld_d[head_q] = 1'b0;
        if (br_squash) begin
            for (int i = 0; i < DEPTH; i++)
                if (mask_q[i][br_resolve_idx]) vld_d[i] = 1'b0;
        end
        if (alloc_fire)
            vld_d[tail_q] = 1'b1;
        head_d  = head_q + PTR_W'(ls_done);
        iptr_d  = iptr_q + PTR_W'(issue_load);
        tail_d  = (br_squash && sq_found) ? sq_tail : tail_q + PTR_W'(alloc_fire);
        count_d = count_q - (br_squash ? sq_cnt : '0) + CNT_W'(alloc_fire) - CNT_W'(ls_done);
        pend_d  = pend_q - (br_squash ? sq_cnt : '0) + CNT_W'(alloc_fire) - CNT_W'(issue_load);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            iptr_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            iptr_q  <= iptr_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload storage; validity is tracked separately by vld_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            tag1_q[i] <= tag1_d[i];
            tag2_q[i] <= tag2_d[i];
            d1_q[i]   <= d1_d[i];
            d2_q[i]   <= d2_d[i];
            mask_q[i] <= mask_d[i];
        end
        if (alloc_fire) begin
            op_q[tail_q]  <= bus.alloc_op;
            dst_q[tail_q] <= bus.alloc_dst;
            imm_q[tail_q] <= bus.alloc_imm;
        end
    end

    // Issue output register: loads when free or being drained, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q   <= 1'b0;
            iop_q  <= '0;
            idst_q <= '0;
            id1_q  <= '0;
            id2_q  <= '0;
            iimm_q <= '0;
        end else if (issue_load) begin
            iv_q   <= 1'b1;
            iop_q  <= op_q[iptr_q];
            idst_q <= dst_q[iptr_q];
            id1_q  <= d1_d[iptr_q];
            id2_q  <= d2_d[iptr_q];
            iimm_q <= imm_q[iptr_q];
        end else if (bus.issue_ready) begin
            iv_q   <= 1'b0;
        end
    end

    assign bus.alloc_ready = (count_q != CNT_W'(DEPTH));
    assign bus.issue_valid = iv_q;
    assign bus.issue_op    = iop_q;
    assign bus.issue_dst   = idst_q;
    assign bus.issue_data1 = id1_q;
    assign bus.issue_data2 = id2_q;
    assign bus.issue_imm   = iimm_q;
    assign count           = count_q;
    assign empty           = (count_q == '0);

    // Retiring requires at least one issued-but-unretired entry.
    a_ls_done_legal: assert property (@(posedge clk) disable iff (rst)
        ls_done |-> (count_q != pend_q));
endmodule
